// File: rtl/param_stack.sv
// param_stack: parametrised LIFO with registered top-of-stack, count/empty/full status and overflow/underflow pulses.
// Optional build macro PARAM_STACK_STICKY_ERR_EN makes `error` sticky until reset;
// without it `error` pulses together with overflow/underflow.
// The top entry lives in a register; the DEPTH-1 lower levels sit in an unreset array
// read combinationally so a pop completes in the same edge.
module param_stack #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 32,
  parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  error
);
  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH - 1) : 1;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH-1];
  logic [DATA_WIDTH-1:0] top_q, top_d, rd;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  empty_q, empty_d, full_q, full_d;
  logic                  ovf_q, ovf_d, unf_q, unf_d, err_q, err_d;
  logic                  do_push, do_pop, wr_en;
  logic [AW-1:0]         wr_idx, rd_idx;
  // Next-state: a push while empty ignores a simultaneous pop; push+pop on a non-empty stack replaces the top
  always_comb begin
    do_push = push & (pop ? empty_q : ~full_q);
    do_pop  = pop & ~push & ~empty_q;
    wr_en   = do_push & ~empty_q;
    wr_idx  = AW'(cnt_q - CNT_WIDTH'(1));
    rd_idx  = AW'(cnt_q - CNT_WIDTH'(2));
    rd      = (cnt_q >= CNT_WIDTH'(2)) ? mem_q[rd_idx] : '0;
    top_d   = (push & (pop | ~full_q)) ? data_in : do_pop ? rd : top_q;
    cnt_d   = cnt_q + CNT_WIDTH'(do_push) - CNT_WIDTH'(do_pop);
    empty_d = cnt_d == '0;
    full_d  = cnt_d == CNT_WIDTH'(DEPTH);
    ovf_d   = push & ~pop & full_q;
    unf_d   = pop & empty_q;
`ifdef PARAM_STACK_STICKY_ERR_EN
    err_d   = err_q | ovf_d | unf_d;
`else
    err_d   = ovf_d | unf_d;
`endif
  end
  // Top register and status flags, all reset; reset wins over any strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      top_q   <= '0;
      cnt_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      top_q   <= top_d;
      cnt_q   <= cnt_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      err_q   <= err_d;
    end
  end
  // Lower levels: the old top spills into the array on a push into a non-empty stack
  always_ff @(posedge clk) begin
    if (!reset && wr_en) mem_q[wr_idx] <= top_q;
  end
  assign data_out  = top_q;
  assign count     = cnt_q;
  assign empty     = empty_q;
  assign full      = full_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign error     = err_q;
endmodule

// File: tb/tb_param_stack.sv
// tb_param_stack: scoreboard bench for param_stack (DEPTH=4 directed scenarios, DEPTH=5 randomised).
module tb_param_stack;
`ifdef PARAM_STACK_STICKY_ERR_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif
  localparam logic [15:0] RST_V = {8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic push4 = 1'b0, pop4 = 1'b0, push5 = 1'b0, pop5 = 1'b0;
  logic [7:0] din4 = '0, din5 = '0, dout4, dout5;
  logic [2:0] cnt4, cnt5;
  logic emp4, ful4, ovf4, unf4, err4, emp5, ful5, ovf5, unf5, err5;
  logic [15:0] obs4, obs5, e;
  logic [15:0] q4[$], q5[$];
  logic [63:0] stk4 = '0, stk5 = '0;
  int c4 = 0, c5 = 0;
  bit r4 = 0, r5 = 0;
  int ncmp = 0, nerr = 0;
  always #5 clk = ~clk;
  param_stack #(.DATA_WIDTH(8), .DEPTH(4)) u4 (
    .clk(clk), .reset(reset), .push(push4), .pop(pop4), .data_in(din4), .data_out(dout4),
    .count(cnt4), .empty(emp4), .full(ful4), .overflow(ovf4), .underflow(unf4), .error(err4));
  param_stack #(.DATA_WIDTH(8), .DEPTH(5)) u5 (
    .clk(clk), .reset(reset), .push(push5), .pop(pop5), .data_in(din5), .data_out(dout5),
    .count(cnt5), .empty(emp5), .full(ful5), .overflow(ovf5), .underflow(unf5), .error(err5));
  assign obs4 = {dout4, cnt4, emp4, ful4, ovf4, unf4, err4};
  assign obs5 = {dout5, cnt5, emp5, ful5, ovf5, unf5, err5};
  // Reference LIFO: packed byte array with an entry count, top at index cnt-1
  function automatic void mstep(input int depth, inout logic [63:0] stk, inout int cnt, inout bit er,
                                input bit pu, input bit po, input logic [7:0] d, output logic [15:0] ev);
    bit ovf, unf;
    logic [7:0] top;
    ovf = pu && !po && cnt == depth;
    unf = po && cnt == 0;
    if (pu && po && cnt > 0) stk[8*(cnt-1) +: 8] = d;
    else if (pu && !ovf) begin stk[8*cnt +: 8] = d; cnt++; end
    else if (po && cnt > 0) cnt--;
    er = STICKY ? (er | ovf | unf) : (ovf | unf);
    top = (cnt > 0) ? stk[8*(cnt-1) +: 8] : 8'h00;
    ev = {top, 3'(cnt), cnt == 0, cnt == depth, ovf, unf, er};
  endfunction
  task automatic op4(input bit pu, input bit po, input logic [7:0] d);
    logic [15:0] ev;
    @(negedge clk);
    reset = 1'b0; push4 = pu; pop4 = po; din4 = d;
    mstep(4, stk4, c4, r4, pu, po, d, ev);
    q4.push_back(ev);
    @(posedge clk); #1;
  endtask
  task automatic op5(input bit pu, input bit po, input logic [7:0] d);
    logic [15:0] ev;
    @(negedge clk);
    reset = 1'b0; push5 = pu; pop5 = po; din5 = d;
    mstep(5, stk5, c5, r5, pu, po, d, ev);
    q5.push_back(ev);
    @(posedge clk); #1;
  endtask
  task automatic rst_cycle(input bit sel5, input bit pu);
    @(negedge clk);
    reset = 1'b1; push4 = pu; pop4 = 1'b0; din4 = 8'h99; push5 = pu; pop5 = 1'b0; din5 = 8'h99;
    stk4 = '0; c4 = 0; r4 = 0; stk5 = '0; c5 = 0; r5 = 0;
    if (sel5) q5.push_back(RST_V); else q4.push_back(RST_V);
    @(posedge clk); #1;
  endtask
  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      if (i < 2) rst_cycle(0, 1); else op4(0, 0, 8'h00);
      e = q4.pop_front(); ncmp++;
      if (obs4 !== e) begin nerr++; $display("FAIL reset[%0d] {dout,cnt,emp,full,ovf,unf,err} got=%h exp=%h", i, obs4, e); end
    end
  endtask
  task automatic test_push();
    logic [7:0] v[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 6; i++) begin
      if (i < 5) op4(1, 0, v[i]); else op4(0, 0, 8'h00);
      e = q4.pop_front(); ncmp++;
      if (obs4 !== e) begin nerr++; $display("FAIL push[%0d] {dout,cnt,emp,full,ovf,unf,err} got=%h exp=%h", i, obs4, e); end
    end
  endtask
  task automatic test_pop();
    for (int i = 0; i < 6; i++) begin
      if (i < 5) op4(0, 1, 8'h00); else op4(0, 0, 8'h00);
      e = q4.pop_front(); ncmp++;
      if (obs4 !== e) begin nerr++; $display("FAIL pop[%0d] {dout,cnt,emp,full,ovf,unf,err} got=%h exp=%h", i, obs4, e); end
    end
  endtask
  task automatic test_simultaneous();
    bit pu[7] = '{1, 1, 1, 0, 0, 1, 0};
    bit po[7] = '{0, 0, 1, 1, 1, 1, 0};
    logic [7:0] d[7] = '{8'h11, 8'h22, 8'hAA, 8'h00, 8'h00, 8'h5A, 8'h00};
    for (int i = 0; i < 7; i++) begin
      op4(pu[i], po[i], d[i]);
      e = q4.pop_front(); ncmp++;
      if (obs4 !== e) begin nerr++; $display("FAIL simul[%0d] {dout,cnt,emp,full,ovf,unf,err} got=%h exp=%h", i, obs4, e); end
    end
  endtask
  task automatic test_error();
    for (int i = 0; i < 15; i++) begin
      if (i < 4) op4(1, 0, 8'(8'hC0 + i)); else op4(0, 0, 8'h00);
      e = q4.pop_front(); ncmp++;
      if (obs4 !== e) begin nerr++; $display("FAIL error[%0d] {dout,cnt,emp,full,ovf,unf,err} got=%h exp=%h", i, obs4, e); end
    end
    rst_cycle(0, 0);
    e = q4.pop_front(); ncmp++;
    if (obs4 !== e) begin nerr++; $display("FAIL error_reset {dout,cnt,emp,full,ovf,unf,err} got=%h exp=%h", obs4, e); end
  endtask
  task automatic test_back_to_back();
    rst_cycle(1, 0);
    e = q5.pop_front(); ncmp++;
    if (obs5 !== e) begin nerr++; $display("FAIL rand_reset {dout,cnt,emp,full,ovf,unf,err} got=%h exp=%h", obs5, e); end
    for (int i = 0; i < 2000; i++) begin
      op5(($urandom % 100) < 55, ($urandom % 100) < 45, 8'($urandom));
      e = q5.pop_front(); ncmp++;
      if (obs5 !== e) begin nerr++; $display("FAIL rand[%0d] {dout,cnt,emp,full,ovf,unf,err} got=%h exp=%h", i, obs5, e); end
    end
  endtask
  initial begin
    test_reset();
    test_push();
    test_pop();
    test_simultaneous();
    test_error();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/param_stack.md
# param_stack

Parametrised LIFO stack for the push/pop switch front-ends: generalises the fixed 8-bit stack to configurable data width and depth, and adds full/empty/count status, a registered top-of-stack output, and defined simultaneous push+pop (replace-top) behaviour. It sits after the debounce FSMs, which supply single-cycle `push`/`pop` strobes, and drives board LEDs and the ILA probes.

## Interface
Parameters:
- DATA_WIDTH, 8, bits per entry (≥1)
- DEPTH, 32, number of entries (≥2, any integer, not restricted to powers of two)
- CNT_WIDTH, $clog2(DEPTH+1), width of `count` (derived; do not override)

Ports:
- clk  input  1  single clock; all logic on the rising edge
- reset  input  1  synchronous, active-high reset
- push  input  1  push strobe; `data_in` is sampled on the same edge
- pop  input  1  pop strobe
- data_in  input  DATA_WIDTH  value to push
- data_out  output  DATA_WIDTH  registered top-of-stack; 0 when empty
- count  output  CNT_WIDTH  number of stored entries, 0..DEPTH
- empty  output  1  count == 0
- full  output  1  count == DEPTH
- overflow  output  1  one-cycle pulse: push rejected
- underflow  output  1  one-cycle pulse: pop rejected
- error  output  1  error indication (see Configuration)

## Operation
- Storage: a top register holding `data_out`, plus a RAM/array of DEPTH-1 entries for lower levels. The array is not reset. The top register and all status registers are reset.
- Reset values: data_out=0, count=0, empty=1, full=0, overflow=0, underflow=0, error=0. Reset has priority over push/pop on the same edge; a reset mid-sequence discards all contents.
- Per-edge action, with state evaluated before the edge:
  - push only, not full: old top moves to array[count-1] if count≥1; top←data_in; count+1.
  - push only, full: no change; overflow=1.
  - pop only, count≥2: top←array[count-2]; count-1.
  - pop only, count==1: top←0; count=0.
  - pop only, empty: no change; underflow=1.
  - push+pop, count≥1 (including full): replace top, so top←data_in; count unchanged; no error.
  - push+pop, empty: push performed (top←data_in, count=1); pop ignored; underflow=1.
  - neither: hold.
- `empty`/`full` are registered and consistent with `count` on every cycle.
- The array read for a pop must be available at the same edge. Use a combinational read of the array, or a registered shadow of array[count-2]. Zero-latency pop is mandatory.

## Timing
- All outputs are registered. The effect of an operation sampled at edge N is visible immediately after edge N.
- Back-to-back strobes on every cycle are supported with no bubbles. Throughput is one operation per cycle.
- overflow/underflow are high for exactly the one cycle following the offending edge. They deassert on the next edge unless that edge is also an error.
- No handshake or ready signal. Rejected operations are dropped, and the caller observes the pulse.

## Configuration
- Macro: `PARAM_STACK_STICKY_ERR_EN`.
- Defined: `error` sets on any overflow or underflow pulse and stays high until `reset`.
- Undefined: `error` = overflow | underflow, a one-cycle pulse with identical timing to those outputs.
- overflow/underflow behave the same in both builds.

## Test plan
All scenarios use DATA_WIDTH=8, DEPTH=4.
- Reset then idle: data_out=0x00, count=0, empty=1, full=0, error=0. Pushing with reset held leaves count=0.
- Push 0x11, 0x22, 0x33, 0x44 on consecutive cycles: data_out follows 0x11→0x44; count 1→4; full=1 after the 4th edge. A fifth push of 0x55 gives overflow for one cycle, data_out stays 0x44, count stays 4.
- Pop ×4 from the state above: data_out 0x33, 0x22, 0x11, 0x00; empty=1 after the 4th. A fifth pop gives one-cycle underflow and count=0.
- Simultaneous events:
  - With stack [0x11,0x22], push+pop 0xAA gives data_out=0xAA, count=2. A following pop gives data_out=0x11.
  - On empty, push+pop 0x5A gives data_out=0x5A, count=1, underflow=1.
- Error mode: after an overflow, `error` is high for 1 cycle in the default build. With `PARAM_STACK_STICKY_ERR_EN` it stays high through 10 idle cycles and clears only on reset.
- Randomised strobes over 2000 cycles with an odd DEPTH=5, checked against a reference queue model: data_out, count, full, empty and pulses match every cycle.
